datapath_seq: RTL

- Parametrised next-generation single-bus CPU datapath: NREGS x WIDTH general register file, HI/LO, PC, IR, Y, Z (high/low), MDR, MAR and in-port on one shared bus.
- Adds a priority bus encoder with a contention flag.
- Adds an iterative multi-cycle multiply/divide sequencer with a start/busy/done handshake beside the single-cycle ALU.
- Sits between the control unit (drives enables/selects) and memory (mdatain, mar_q).

---
 rtl/datapath_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_seq.sv
// Single-bus CPU datapath with a priority bus encoder, single-cycle ALU and an iterative MUL/DIV sequencer.
// Optional feature: define SIGNED_MULDIV_EN for two's-complement MUL/DIV with an extra sign-fix state.
module datapath_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] mdatain,
  input  logic [WIDTH-1:0] inport_data,
  input  logic             read,
  input  logic             inc_pc,
  input  logic [NREGS-1:0] reg_in,
  input  logic [NREGS-1:0] reg_out,
  input  logic             pc_in,
  input  logic             ir_in,
  input  logic             y_in,
  input  logic             z_in,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic             mdr_in,
  input  logic             mar_in,
  input  logic             pc_out,
  input  logic             zhi_out,
  input  logic             zlo_out,
  input  logic             hi_out,
  input  logic             lo_out,
  input  logic             mdr_out,
  input  logic             inport_out,
  input  logic [4:0]       opcode,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bus_conflict,
  output logic [WIDTH-1:0] bus_value,
  output logic [WIDTH-1:0] mar_q,
  output logic [WIDTH-1:0] ir_q
);

  localparam int unsigned NSRC = NREGS + 7;
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SHR = 5'b00100;
  localparam logic [4:0] OP_SHL = 5'b00101;
  localparam logic [4:0] OP_NEG = 5'b00110;
  localparam logic [4:0] OP_NOT = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01001;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_FIN} state_t;

  logic [WIDTH-1:0] gpr [NREGS];
  logic [WIDTH-1:0] hi, lo, z_hi, z_lo, pc, ir, y, mdr, mar;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_orig;
  logic             op_div, b_zero, neg_q, neg_r;

  assign mar_q = mar;
  assign ir_q  = ir;

  // Bus sources in priority order: lowest index wins
  logic [NSRC-1:0]  sel;
  logic [WIDTH-1:0] src [NSRC];

  assign sel          = {inport_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, reg_out};
  assign bus_conflict = |(sel & (sel - NSRC'(1)));

  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) src[i] = gpr[i];
    src[NREGS]     = hi;
    src[NREGS + 1] = lo;
    src[NREGS + 2] = z_hi;
    src[NREGS + 3] = z_lo;
    src[NREGS + 4] = pc;
    src[NREGS + 5] = mdr;
    src[NREGS + 6] = inport_data;
    bus_value = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (sel[i]) bus_value = src[i];
    end
  end

  // Single-cycle ALU: A = Y, B = bus
  logic [WIDTH-1:0] alu_hi, alu_lo;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [4:0]       shamt;

  always_comb begin
    alu_hi  = '0;
    alu_lo  = '0;
    shamt   = bus_value[4:0];
    add_ext = {1'b0, y} + {1'b0, bus_value};
    sub_ext = {1'b0, y} - {1'b0, bus_value};
    if (inc_pc) begin
      alu_lo = bus_value + WIDTH'(1);
    end else begin
      case (opcode)
        OP_ADD: begin alu_lo = add_ext[WIDTH-1:0]; alu_hi[0] = add_ext[WIDTH]; end
        OP_SUB: begin alu_lo = sub_ext[WIDTH-1:0]; alu_hi[0] = sub_ext[WIDTH]; end
        OP_AND: alu_lo = y & bus_value;
        OP_OR:  alu_lo = y | bus_value;
        OP_SHR: alu_lo = (32'(shamt) >= WIDTH) ? '0 : (y >> shamt);
        OP_SHL: alu_lo = (32'(shamt) >= WIDTH) ? '0 : (y << shamt);
        OP_NEG: alu_lo = -bus_value;
        OP_NOT: alu_lo = ~bus_value;
        default: ;
      endcase
    end
  end

  // Sequencer step datapath: shift-add multiply, restoring divide
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg, start_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH + 1)'(0));
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
`ifdef SIGNED_MULDIV_EN
    a_neg = y[WIDTH-1];
    b_neg = bus_value[WIDTH-1];
`else
    a_neg = 1'b0;
    b_neg = 1'b0;
`endif
    a_mag    = a_neg ? -y : y;
    b_mag    = b_neg ? -bus_value : bus_value;
    start_ok = start && (state == S_IDLE) && ((opcode == OP_MUL) || (opcode == OP_DIV));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      a_orig <= '0;
      op_div <= 1'b0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            op_div <= (opcode == OP_DIV);
            b_zero <= (bus_value == '0);
            a_orig <= y;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc_hi <= '0;
            acc_lo <= (opcode == OP_DIV) ? a_mag : b_mag;
            opnd   <= (opcode == OP_DIV) ? b_mag : a_mag;
          end
        end
        S_RUN: begin
          if (op_div) begin
            acc_hi <= div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIGNED_MULDIV_EN
            state <= S_FIX;
`else
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
        S_FIX: begin
          // Magnitudes were processed; restore signs of quotient/product and remainder
          if (op_div) begin
            if (neg_q) acc_lo <= -acc_lo;
            if (neg_r) acc_hi <= -acc_hi;
          end else if (neg_q) begin
            {acc_hi, acc_lo} <= -{acc_hi, acc_lo};
          end
          state <= S_FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file and datapath registers; Z is owned by the sequencer outside IDLE
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(NREGS); i++) gpr[i] <= '0;
      hi   <= '0;
      lo   <= '0;
      z_hi <= '0;
      z_lo <= '0;
      pc   <= '0;
      ir   <= '0;
      y    <= '0;
      mdr  <= '0;
      mar  <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (reg_in[i]) gpr[i] <= bus_value;
      end
      if (hi_in)  hi  <= bus_value;
      if (lo_in)  lo  <= bus_value;
      if (pc_in)  pc  <= bus_value;
      if (ir_in)  ir  <= bus_value;
      if (y_in)   y   <= bus_value;
      if (mar_in) mar <= bus_value;
      if (mdr_in) mdr <= read ? mdatain : bus_value;
      if (state == S_FIN) begin
        z_hi <= (op_div && b_zero) ? a_orig : acc_hi;
        z_lo <= (op_div && b_zero) ? '1 : acc_lo;
      end else if (z_in && (state == S_IDLE)) begin
        z_hi <= alu_hi;
        z_lo <= alu_lo;
      end
    end
  end

endmodule
